segment_scroll_display: RTL and testbench
=========================================

Name: segment_scroll_display

Overview:
- Sits directly downstream of the character segment driver. Consumes its 32-bit character word: four 8-bit ASCII codes, with bits 31:24 as the leftmost character.
- Drives the board's two 7-segment digits, which are active-low. Shows a 2-character window that scrolls circularly across the four characters at a fixed tick rate.
- Holds display state across loads and provides a wrap strobe for downstream sequencing.

Parameters:
- SCROLL_TICKS, 25000000: clock cycles per scroll step (1 s at 25 MHz). Legal minimum is 2. The tick counter is $clog2(SCROLL_TICKS) bits wide.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Character  in  32  four ASCII codes; char[3]=31:24, char[2]=23:16, char[1]=15:8, char[0]=7:0.
- i_Load  in  1  single-cycle strobe; captures i_Character.
- i_Hold  in  1  level; freezes scrolling while high.
- o_Segment1  out  7  left digit, active-low, bit6..0 = G,F,E,D,C,B,A.
- o_Segment2  out  7  right digit, same encoding.
- o_Wrap  out  1  one-cycle pulse when the window position wraps 3->0.
- o_Active  out  1  high in S_SHOW.

Behaviour:
- One clock domain. Reset is asynchronous on the falling edge of i_Rst_n; release is synchronous to i_Clk.
- Reset values:
  - state = S_IDLE; buffer = 32'h20202020; position = 0; tick counter = 0.
  - o_Segment1 = o_Segment2 = 7'h7F (all off); o_Wrap = 0; o_Active = 0.
- States:
  - S_IDLE: both digits 7'h7F, no counting. i_Load -> S_SHOW.
  - S_SHOW: displays char[3-p] on digit 1 and char[3-((p+1)%4)] on digit 2, where p = position 0..3.
  - There is no exit from S_SHOW except reset.
- Load:
  - On a clock edge with i_Load=1: buffer <= i_Character, position <= 0, tick counter <= 0, state <= S_SHOW.
  - Latency: buffer is updated at edge N+1. Segment outputs are registered and reflect the new window at edge N+2.
  - A load in S_SHOW restarts the scroll and does not pulse o_Wrap.
- Scroll:
  - In S_SHOW with i_Hold=0, the tick counter increments each cycle.
  - When the counter = SCROLL_TICKS-1: counter <= 0 and position <= position+1 mod 4.
  - On the 3->0 transition, o_Wrap = 1 for exactly one cycle, registered and coincident with the segment update.
- Hold:
  - i_Hold=1 freezes both counter and position. Release resumes from the frozen count; the count is not reset.
- Simultaneous events:
  - i_Load and counter terminal count in the same cycle: load wins, position = 0, no o_Wrap.
  - i_Load with i_Hold=1: load is still captured, and the counter stays 0 until hold is released.
- Glyph decode (combinational, then registered; active-low):
  - '0'-'9' (0x30-0x39) and 'A'-'F' (0x41-0x46) use standard hex glyphs: '0'=7'h40, '1'=7'h79, '2'=7'h24, 'A'=7'h08.
  - 0x20 = 7'h7F (blank).
  - Any other code = 7'h3F (dash, segment G only).
- Reset mid-scroll: all state and outputs return to reset values immediately (asynchronous). Nothing is retained.

Optional Feature:
- Macro SEG_CHANGE_LOAD_EN.
  - Defined: an internal load is generated whenever i_Character != buffer, in addition to i_Load. The block then tracks the upstream driver with no strobe required. i_Character equal to buffer generates no reload, so there is no continuous restart.
  - Undefined: only i_Load captures, and i_Character is ignored otherwise.

Test Plan (SCROLL_TICKS=4):
- Reset asserted mid-cycle, then released -> o_Segment1 = o_Segment2 = 7'h7F, o_Wrap=0, o_Active=0; no change without i_Load.
- i_Character=32'h31322030 ("12 0") with i_Load pulse at edge N:
  - Edge N+2: o_Segment1=7'h79, o_Segment2=7'h24, o_Active=1.
  - 4 cycles later: 7'h24 / 7'h7F.
  - Then: 7'h7F / 7'h40.
  - Then: 7'h40 / 7'h79.
  - Next step: back to 7'h79 / 7'h24 with o_Wrap high for exactly 1 cycle.
- i_Hold=1 for 10 cycles at position 1 -> outputs stay 7'h24 / 7'h7F. After release, the step occurs after the remaining count, not after a full 4 cycles.
- i_Load of 32'h41477E46 in the terminal-count cycle -> window 7'h08 / 7'h3F at position 0 ('G' and '~' decode to dash), no o_Wrap.
- With SEG_CHANGE_LOAD_EN defined, change i_Character from 32'h31322030 to 32'h30303030 without i_Load -> both digits 7'h40 two edges later, position 0. Hold i_Character steady for 20 cycles -> normal scrolling, no restart.

Source files
------------

// File: rtl/segment_scroll_display.sv
// Two-digit active-low 7-segment scroller over a 4-character ASCII word.
// Ports: i_Clk, i_Rst_n, i_Character[31:0], i_Load, i_Hold -> o_Segment1/2[6:0], o_Wrap, o_Active.
// Optional macro SEG_CHANGE_LOAD_EN: reload whenever i_Character differs from the held buffer.
module segment_scroll_display #(
  parameter int SCROLL_TICKS = 25000000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [31:0] i_Character,
  input  logic        i_Load,
  input  logic        i_Hold,
  output logic [6:0]  o_Segment1,
  output logic [6:0]  o_Segment2,
  output logic        o_Wrap,
  output logic        o_Active
);

  localparam int CW = (SCROLL_TICKS > 2) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCROLL_TICKS - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {
    S_IDLE,
    S_SHOW
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   buf_q, buf_d;
  logic [1:0]    pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wev_q, wev_d;
  logic [6:0]    seg1_q, seg1_d;
  logic [6:0]    seg2_q, seg2_d;
  logic          wrap_q, wrap_d;
  logic          act_q, act_d;

  logic          load;
  logic [1:0]    idx1, idx2;

  function automatic logic [7:0] char_at(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    logic [7:0] c;
    c = 8'h20;
    unique case (i)
      2'd3: c = w[31:24];
      2'd2: c = w[23:16];
      2'd1: c = w[15:8];
      2'd0: c = w[7:0];
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] glyph(
    input logic [7:0] c
  );
    logic [6:0] g;
    g = 7'h3F;
    case (c)
      8'h30: g = 7'h40;
      8'h31: g = 7'h79;
      8'h32: g = 7'h24;
      8'h33: g = 7'h30;
      8'h34: g = 7'h19;
      8'h35: g = 7'h12;
      8'h36: g = 7'h02;
      8'h37: g = 7'h78;
      8'h38: g = 7'h00;
      8'h39: g = 7'h10;
      8'h41: g = 7'h08;
      8'h42: g = 7'h03;
      8'h43: g = 7'h46;
      8'h44: g = 7'h21;
      8'h45: g = 7'h06;
      8'h46: g = 7'h0E;
      8'h20: g = 7'h7F;
      default: g = 7'h3F;
    endcase
    return g;
  endfunction

`ifdef SEG_CHANGE_LOAD_EN
  // Equal word never reloads, so a steady upstream does not restart the scroll.
  assign load = i_Load | (i_Character != buf_q);
`else
  assign load = i_Load;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    wev_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          buf_d   = i_Character;
          pos_d   = 2'd0;
          cnt_d   = '0;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        // Load beats terminal count: restart from position 0, no wrap.
        if (load) begin
          buf_d = i_Character;
          pos_d = 2'd0;
          cnt_d = '0;
        end else if (!i_Hold) begin
          if (cnt_q == TERM) begin
            cnt_d = '0;
            pos_d = pos_q + 2'd1;
            wev_d = (pos_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // 2-bit arithmetic gives the circular window for free.
  assign idx1 = 2'd3 - pos_q;
  assign idx2 = 2'd3 - (pos_q + 2'd1);

  always_comb begin
    seg1_d = BLANK;
    seg2_d = BLANK;
    act_d  = 1'b0;
    wrap_d = wev_q;
    if (state_q == S_SHOW) begin
      seg1_d = glyph(char_at(buf_q, idx1));
      seg2_d = glyph(char_at(buf_q, idx2));
      act_d  = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= 32'h20202020;
      pos_q   <= 2'd0;
      cnt_q   <= '0;
      wev_q   <= 1'b0;
      seg1_q  <= BLANK;
      seg2_q  <= BLANK;
      wrap_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      wev_q   <= wev_d;
      seg1_q  <= seg1_d;
      seg2_q  <= seg2_d;
      wrap_q  <= wrap_d;
      act_q   <= act_d;
    end
  end

  assign o_Segment1 = seg1_q;
  assign o_Segment2 = seg2_q;
  assign o_Wrap     = wrap_q;
  assign o_Active   = act_q;

endmodule

// File: tb/tb_segment_scroll_display.sv
// Bench for segment_scroll_display: reference model plus directed literal checks.
// Random load/hold/character stimulus compared every cycle.
module tb_segment_scroll_display;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] chr;
  logic        load;
  logic        hold;
  logic [6:0]  seg1;
  logic [6:0]  seg2;
  logic        wrap;
  logic        act;

  int checks;
  int errors;

  segment_scroll_display #(
    .SCROLL_TICKS(T)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Character(chr),
    .i_Load(load),
    .i_Hold(hold),
    .o_Segment1(seg1),
    .o_Segment2(seg2),
    .o_Wrap(wrap),
    .o_Active(act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [7:0] c);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (c >= 8'h30 && c <= 8'h39) return tab[c - 8'h30];
    if (c >= 8'h41 && c <= 8'h46) return tab[c - 8'h41 + 10];
    if (c == 8'h20) return 7'h7F;
    return 7'h3F;
  endfunction

  function automatic logic [7:0] ref_char(input logic [31:0] w, input int k);
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  // Model: "run" counts un-held cycles since the last load; the
  // window position is simply run / T, taken mod 4.
  logic        m_show;
  logic [31:0] m_buf;
  int          m_run;
  logic        m_wev;
  logic        m_ld;
  int          m_p;
  int          m_np;
  logic [6:0]  e_seg1;
  logic [6:0]  e_seg2;
  logic        e_wrap;
  logic        e_act;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_show = 1'b0;
      m_buf  = 32'h20202020;
      m_run  = 0;
      m_wev  = 1'b0;
      e_seg1 = 7'h7F;
      e_seg2 = 7'h7F;
      e_wrap = 1'b0;
      e_act  = 1'b0;
    end else begin
      m_p    = (m_run / T) % 4;
      e_seg1 = m_show ? ref_glyph(ref_char(m_buf, 3 - m_p)) : 7'h7F;
      e_seg2 = m_show ? ref_glyph(ref_char(m_buf, 3 - ((m_p + 1) % 4))) : 7'h7F;
      e_wrap = m_wev;
      e_act  = m_show;
      m_ld   = load;
`ifdef SEG_CHANGE_LOAD_EN
      if (chr != m_buf) m_ld = 1'b1;
`endif
      if (m_ld) begin
        m_buf  = chr;
        m_run  = 0;
        m_show = 1'b1;
        m_wev  = 1'b0;
      end else if (m_show && !hold) begin
        m_run = (m_run + 1) % (4 * T);
        m_np  = (m_run / T) % 4;
        m_wev = (m_p == 3) && (m_np == 0);
      end else begin
        m_wev = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (seg1 !== e_seg1) begin
      errors++;
      $display("FAIL model_seg1 t=%0t got=%h exp=%h", $time, seg1, e_seg1);
    end
    checks++;
    if (seg2 !== e_seg2) begin
      errors++;
      $display("FAIL model_seg2 t=%0t got=%h exp=%h", $time, seg2, e_seg2);
    end
    checks++;
    if (wrap !== e_wrap) begin
      errors++;
      $display("FAIL model_wrap t=%0t got=%b exp=%b", $time, wrap, e_wrap);
    end
    checks++;
    if (act !== e_act) begin
      errors++;
      $display("FAIL model_active t=%0t got=%b exp=%b", $time, act, e_act);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic win(input string name, input logic [6:0] a, input logic [6:0] b);
    chk({name, "_s1"}, {25'd0, seg1}, {25'd0, a});
    chk({name, "_s2"}, {25'd0, seg2}, {25'd0, b});
  endtask

  function automatic logic [31:0] pick_char();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 5))
        0: w[8*i +: 8] = 8'(8'h30 + $urandom_range(0, 9));
        1: w[8*i +: 8] = 8'(8'h41 + $urandom_range(0, 5));
        2: w[8*i +: 8] = 8'h20;
        3: w[8*i +: 8] = 8'h47;
        4: w[8*i +: 8] = 8'h7E;
        default: w[8*i +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return w;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    hold   = 1'b0;
    chr    = 32'h20202020;
    step(2);
    rst_n = 1'b1;
    step(1);
    win("reset", 7'h7F, 7'h7F);
    chk("reset_wrap", {31'd0, wrap}, 32'd0);
    chk("reset_active", {31'd0, act}, 32'd0);
    step(3);
    win("idle", 7'h7F, 7'h7F);

    // Scroll through "12 0" and around to the wrap.
    chr  = 32'h31322030;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    win("p0", 7'h79, 7'h24);
    chk("p0_active", {31'd0, act}, 32'd1);
    step(4);
    win("p1", 7'h24, 7'h7F);
    step(4);
    win("p2", 7'h7F, 7'h40);
    step(4);
    win("p3", 7'h40, 7'h79);
    step(4);
    win("wrap_win", 7'h79, 7'h24);
    chk("wrap_pulse", {31'd0, wrap}, 32'd1);
    step(1);
    chk("wrap_once", {31'd0, wrap}, 32'd0);

    // Hold at position 1, then resume from the frozen count.
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(5);
    win("hold_pre", 7'h24, 7'h7F);
    hold = 1'b1;
    step(10);
    win("hold_frozen", 7'h24, 7'h7F);
    hold = 1'b0;
    step(3);
    win("hold_rem", 7'h24, 7'h7F);
    step(1);
    win("hold_step", 7'h7F, 7'h40);

    // Load exactly on the terminal count that would wrap 3->0.
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(15);
    chr  = 32'h41477E46;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    win("tc_load", 7'h08, 7'h3F);
    chk("tc_nowrap", {31'd0, wrap}, 32'd0);
    step(1);
    chk("tc_nowrap2", {31'd0, wrap}, 32'd0);

`ifdef SEG_CHANGE_LOAD_EN
    chr  = 32'h31322030;
    step(6);
    chr  = 32'h30303030;
    step(2);
    win("chg_load", 7'h40, 7'h40);
    step(20);
    chk("chg_active", {31'd0, act}, 32'd1);
`endif

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    win("async_rst", 7'h7F, 7'h7F);
    chk("async_rst_act", {31'd0, act}, 32'd0);
    chr = 32'h20202020;
    step(1);
    rst_n = 1'b1;
    step(3);
    win("post_rst", 7'h7F, 7'h7F);

    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 15) == 0);
      hold = ($urandom_range(0, 3) == 0);
      if (load || $urandom_range(0, 31) == 0) chr = pick_char();
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step(1);
    end
    load = 1'b0;
    hold = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
